// File: rtl/triangle_fetch_controller_pkg.sv
// Shared triangle-pipeline types (the proctypes definitions): triangle words,
// addresses, decoded instructions and the fetch FSM encoding.
package triangle_fetch_controller_pkg;

  localparam int MAX_TRIANGLES = 1024;
  localparam int ADDR_W        = $clog2(MAX_TRIANGLES);
  localparam int TRI_W         = 96;

  typedef logic [TRI_W-1:0]  Triangle;
  typedef logic [ADDR_W-1:0] TriangleAddr;
  typedef logic [ADDR_W:0]   TriangleCount;

  typedef enum logic [3:0] {
    opNop    = 4'd0,
    opFrame  = 4'd1,
    opRender = 4'd2,
    opDraw   = 4'd3
  } InstType;

  typedef struct packed {
    InstType     iType;
    logic [27:0] imm;
  } DecodedInst;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } FetchState;

  // Counts beyond the memory capacity are clamped rather than wrapped.
  function automatic TriangleCount clamp_count(input TriangleCount n);
    return (n > TriangleCount'(MAX_TRIANGLES)) ? TriangleCount'(MAX_TRIANGLES) : n;
  endfunction

endpackage

// File: rtl/triangle_fetch_controller_if.sv
// Bundle of everything the fetch controller exchanges with the execute stage,
// triangle memory and rasteriser, plus a debug view of the FSM state.
interface triangle_fetch_controller_if;
  import triangle_fetch_controller_pkg::*;

  logic         execInst_valid;
  DecodedInst   execInst;
  TriangleCount tri_count;

  logic         mem_ready;
  logic         mem_rd_en;
  TriangleAddr  mem_addr;
  Triangle      mem_rd_data;

  // valid/ready: a transfer happens on every rising clk edge where both are
  // high; once raised, valid holds with stable data until that transfer
  // (abort/restart/reset are the only exceptions).
  logic         next_triangle_valid;
  logic         next_triangle_ready;
  Triangle      next_triangle;

  logic         busy;
  logic         frame_done;
  FetchState    state_dbg;

  modport master (
    input  execInst_valid, execInst, tri_count,
    input  mem_ready, mem_rd_data, next_triangle_ready,
    output mem_rd_en, mem_addr, next_triangle_valid, next_triangle,
    output busy, frame_done, state_dbg
  );

  modport slave (
    output execInst_valid, execInst, tri_count,
    output mem_ready, mem_rd_data, next_triangle_ready,
    input  mem_rd_en, mem_addr, next_triangle_valid, next_triangle,
    input  busy, frame_done, state_dbg
  );
endinterface

// File: rtl/triangle_fetch_controller_fifo.sv
// Synchronous FIFO of triangles with flush; simultaneous push and pop on a
// full FIFO is accepted and leaves the count unchanged.
module triangle_fifo
  import triangle_fetch_controller_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  Triangle       push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output Triangle       head
);

  Triangle       r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && full && !pop));

endmodule

// File: rtl/triangle_fetch_controller.sv
// Streams a frame's triangles from triangle memory to the rasteriser, issuing
// reads only when the output FIFO has a guaranteed free slot (credits).
module triangle_fetch_controller
  import triangle_fetch_controller_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  triangle_fetch_controller_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(MEM_LATENCY + 1);
  localparam int UW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]             r_state;
  TriangleAddr            r_issue_addr;
  TriangleCount           r_count_q;
  TriangleCount           r_accepted;
  logic [MEM_LATENCY-1:0] r_vpipe;
  logic                   r_frame_done;

  logic         w_op_frame;
  logic         w_op_render;
  logic         w_op_any;
  TriangleCount w_new_count;
  logic [CW-1:0] w_fifo_count;
  logic [IW-1:0] w_inflight;
  logic [UW-1:0] w_used;
  logic         w_rd_en;
  logic         w_issue;
  logic         w_last_issue;
  logic         w_push;
  logic         w_pop;
  logic         w_last_pop;
  logic         w_fifo_empty;
  logic         w_fifo_full;
  Triangle      w_head;

  assign w_op_frame  = bus.execInst_valid && (bus.execInst.iType == opFrame);
  assign w_op_render = bus.execInst_valid && (bus.execInst.iType == opRender);
  assign w_op_any    = w_op_frame || w_op_render;
  assign w_new_count = clamp_count(bus.tri_count);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      w_inflight = w_inflight + IW'(r_vpipe[i]);
    end
  end

  // Every slot either holds data or is reserved by a read still in flight.
  assign w_used       = UW'(w_fifo_count) + UW'(w_inflight);
  assign w_rd_en      = (r_state == ST_FETCH) && !w_op_any && (w_used < UW'(FIFO_DEPTH));
  assign w_issue      = w_rd_en && bus.mem_ready;
  assign w_last_issue = w_issue && ({1'b0, r_issue_addr} == (r_count_q - TriangleCount'(1)));
  assign w_push       = r_vpipe[MEM_LATENCY-1] && !w_op_any;
  assign w_pop        = !w_fifo_empty && bus.next_triangle_ready && !w_op_any;
  assign w_last_pop   = w_pop && (r_state == ST_DRAIN) &&
                        ((r_accepted + TriangleCount'(1)) == r_count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_issue_addr <= '0;
      r_count_q    <= '0;
      r_accepted   <= '0;
      r_vpipe      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_op_any) begin
        // Abort or restart: forget in-flight reads so late returns are dropped.
        r_vpipe      <= '0;
        r_issue_addr <= '0;
        r_accepted   <= '0;
        if (w_op_frame) begin
          r_count_q <= w_new_count;
          if (w_new_count == '0) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
          end
        end else begin
          r_state <= ST_IDLE;
        end
      end else begin
        r_vpipe <= (r_vpipe << 1) | MEM_LATENCY'(w_issue);
        if (w_issue) r_issue_addr <= r_issue_addr + TriangleAddr'(1);
        if (w_pop && (r_state != ST_IDLE)) r_accepted <= r_accepted + TriangleCount'(1);
        case (r_state)
          ST_FETCH: if (w_last_issue) r_state <= ST_DRAIN;
          ST_DRAIN: begin
            if (w_last_pop) begin
              r_state      <= ST_IDLE;
              r_frame_done <= 1'b1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  triangle_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (bus.mem_rd_data),
    .pop       (w_pop),
    .flush     (w_op_any),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  assign bus.mem_rd_en           = w_rd_en;
  assign bus.mem_addr            = r_issue_addr;
  assign bus.next_triangle_valid = !w_fifo_empty;
  assign bus.next_triangle       = w_head;
  assign bus.busy                = (r_state != ST_IDLE);
  assign bus.frame_done          = r_frame_done;
  assign bus.state_dbg           = FetchState'(r_state);

  a_full_implies_not_empty: assert property (@(posedge clk) disable iff (rst)
    !(w_fifo_full && w_fifo_empty));

endmodule

// File: tb/tb_triangle_fetch_controller.sv
// Directed bench for the triangle fetch controller: memory responder with a
// fixed read latency, scoreboard of expected triangles, frame_done counting.
module tb_triangle_fetch_controller;
  import triangle_fetch_controller_pkg::*;

  localparam int MEM_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int issue_cnt = 0;
  int exp_addr = 0;
  int fd0;
  int n;

  logic [TRI_W-1:0] exp_q[$];

  TriangleAddr pa [MEM_LATENCY];
  logic        pv [MEM_LATENCY];

  triangle_fetch_controller_if bus();

  triangle_fetch_controller #(
    .MEM_LATENCY (MEM_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic Triangle tri_word(input int a);
    logic [31:0] v;
    v = 32'(a);
    return {32'h7100_0000 | v, 32'h7200_0000 | v, 32'h7300_0000 | v};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= bus.mem_rd_en && bus.mem_ready;
      pa[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_comb begin
    bus.mem_rd_data = pv[MEM_LATENCY-1] ? tri_word(int'(pa[MEM_LATENCY-1])) : {TRI_W{1'b1}};
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en && bus.mem_ready) begin
        issue_cnt++;
        check("issue_addr", 128'(bus.mem_addr), 128'(exp_addr));
        exp_addr++;
      end
      if (bus.next_triangle_valid && bus.next_triangle_ready) begin
        check("pop_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) check("tri_data", 128'(bus.next_triangle), 128'(exp_q.pop_front()));
      end
      if (bus.frame_done) fd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_op(input InstType op, input int cnt);
    bus.execInst_valid = 1'b1;
    bus.execInst       = '{iType: op, imm: '0};
    bus.tri_count      = TriangleCount'(cnt);
    if (op == opFrame) begin
      exp_addr  = 0;
      issue_cnt = 0;
    end
    tick(1);
    bus.execInst_valid = 1'b0;
    bus.execInst       = '{iType: opNop, imm: '0};
  endtask

  task automatic push_frame(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(tri_word(i));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 128'(bus.busy), 128'(0));
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.execInst_valid      = 1'b0;
    bus.execInst            = '{iType: opNop, imm: '0};
    bus.tri_count           = '0;
    bus.mem_ready           = 1'b1;
    bus.next_triangle_ready = 1'b1;
    tick(2);

    // reset state
    check("rst_rd_en", 128'(bus.mem_rd_en), 0);
    check("rst_addr", 128'(bus.mem_addr), 0);
    check("rst_valid", 128'(bus.next_triangle_valid), 0);
    check("rst_busy", 128'(bus.busy), 0);
    check("rst_done", 128'(bus.frame_done), 0);
    check("rst_state", 128'(bus.state_dbg), 128'(IDLE));
    rst = 1'b0;
    tick(1);

    // basic frame: first valid 4 cycles after opFrame, then 1/cycle
    fd0 = fd_cnt;
    push_frame(5);
    issue_op(opFrame, 5);
    check("basic_busy", 128'(bus.busy), 1);
    check("basic_valid_c1", 128'(bus.next_triangle_valid), 0);
    tick(2);
    check("basic_valid_c3", 128'(bus.next_triangle_valid), 0);
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("basic_valid", 128'(bus.next_triangle_valid), 1);
      check("basic_head", 128'(bus.next_triangle), 128'(tri_word(k)));
      check("basic_done_low", 128'(bus.frame_done), 0);
      tick(1);
    end
    check("basic_done_pulse", 128'(bus.frame_done), 1);
    check("basic_busy_fall", 128'(bus.busy), 0);
    check("basic_valid_end", 128'(bus.next_triangle_valid), 0);
    tick(1);
    check("basic_done_1cyc", 128'(bus.frame_done), 0);
    check("basic_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));
    check("basic_q_empty", 128'(exp_q.size()), 0);

    // downstream stall: credits limit issues to FIFO_DEPTH
    fd0 = fd_cnt;
    bus.next_triangle_ready = 1'b0;
    push_frame(10);
    issue_op(opFrame, 10);
    tick(20);
    check("stall_issues", 128'(issue_cnt), 128'(FIFO_DEPTH));
    check("stall_rd_en", 128'(bus.mem_rd_en), 0);
    check("stall_valid", 128'(bus.next_triangle_valid), 1);
    check("stall_head", 128'(bus.next_triangle), 128'(tri_word(0)));
    bus.next_triangle_ready = 1'b1;
    wait_idle("stall_idle", 100);
    check("stall_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));
    check("stall_q_empty", 128'(exp_q.size()), 0);

    // memory stall: mem_ready alternates every cycle
    fd0 = fd_cnt;
    push_frame(6);
    issue_op(opFrame, 6);
    n = 0;
    while (bus.busy && n < 200) begin
      bus.mem_ready = ~bus.mem_ready;
      tick(1);
      n++;
    end
    bus.mem_ready = 1'b1;
    check("mstall_idle", 128'(bus.busy), 0);
    tick(1);
    check("mstall_issues", 128'(issue_cnt), 6);
    check("mstall_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));
    check("mstall_q_empty", 128'(exp_q.size()), 0);

    // abort 3 cycles into a frame: nothing delivered, no frame_done
    fd0 = fd_cnt;
    issue_op(opFrame, 8);
    tick(2);
    issue_op(opRender, 0);
    check("abort_valid", 128'(bus.next_triangle_valid), 0);
    check("abort_busy", 128'(bus.busy), 0);
    check("abort_state", 128'(bus.state_dbg), 128'(IDLE));
    tick(6);
    check("abort_late_valid", 128'(bus.next_triangle_valid), 0);
    check("abort_issues", 128'(issue_cnt), 2);
    check("abort_no_done", 128'(fd_cnt), 128'(fd0));

    // restart mid-frame with a smaller count
    fd0 = fd_cnt;
    push_frame(2);
    issue_op(opFrame, 8);
    tick(5);
    bus.next_triangle_ready = 1'b0;
    issue_op(opFrame, 4);
    check("restart_consumed", 128'(exp_q.size()), 0);
    bus.next_triangle_ready = 1'b1;
    push_frame(4);
    wait_idle("restart_idle", 50);
    check("restart_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));
    check("restart_issues", 128'(issue_cnt), 4);
    check("restart_q_empty", 128'(exp_q.size()), 0);

    // zero-count frame
    fd0 = fd_cnt;
    issue_op(opFrame, 0);
    check("zero_done", 128'(bus.frame_done), 1);
    check("zero_busy", 128'(bus.busy), 0);
    check("zero_rd_en", 128'(bus.mem_rd_en), 0);
    tick(1);
    check("zero_done_fall", 128'(bus.frame_done), 0);
    check("zero_issues", 128'(issue_cnt), 0);
    check("zero_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));

    // reset while draining, then a normal short frame
    fd0 = fd_cnt;
    bus.next_triangle_ready = 1'b0;
    issue_op(opFrame, 3);
    n = 0;
    while (bus.state_dbg != DRAIN && n < 20) begin
      tick(1);
      n++;
    end
    check("rst_reach_drain", 128'(bus.state_dbg), 128'(DRAIN));
    rst = 1'b1;
    tick(1);
    check("mid_rst_valid", 128'(bus.next_triangle_valid), 0);
    check("mid_rst_busy", 128'(bus.busy), 0);
    check("mid_rst_rd_en", 128'(bus.mem_rd_en), 0);
    check("mid_rst_addr", 128'(bus.mem_addr), 0);
    check("mid_rst_done", 128'(bus.frame_done), 0);
    rst = 1'b0;
    bus.next_triangle_ready = 1'b1;
    tick(3);
    check("mid_rst_no_done", 128'(fd_cnt), 128'(fd0));
    push_frame(2);
    issue_op(opFrame, 2);
    wait_idle("post_rst_idle", 50);
    check("post_rst_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));
    check("post_rst_q_empty", 128'(exp_q.size()), 0);

    // oversize count is clamped to the memory capacity
    fd0 = fd_cnt;
    push_frame(MAX_TRIANGLES);
    issue_op(opFrame, 2047);
    wait_idle("clamp_idle", 1200);
    check("clamp_issues", 128'(issue_cnt), 128'(MAX_TRIANGLES));
    check("clamp_fd_cnt", 128'(fd_cnt), 128'(fd0 + 1));
    check("clamp_q_empty", 128'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
